// File: rtl/link_pkg.sv
// link_pkg: shared types and defaults for the wireless link transmit path.
//   arb_state_t : link_tx_arbiter FSM states
//   req_id_t    : identifies which keypad path owns the transmitter
//   DEF_TIMEOUT_CYCLES / DEF_MAX_RETRY : default ack timeout and retry budget
//   ACK_CODE    : byte the remote side returns as an acknowledge (receiver side)
package link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    DONE,
    FAIL
  } arb_state_t;

  typedef enum logic {
    REQ_HOST   = 1'b0,
    REQ_PLAYER = 1'b1
  } req_id_t;

  localparam int         DEF_TIMEOUT_CYCLES = 50;
  localparam int         DEF_MAX_RETRY      = 3;
  localparam logic [7:0] ACK_CODE           = 8'h06;

endpackage

// File: rtl/ack_timer.sv
// ack_timer: up-counter measuring how long the arbiter has waited for rx_ack.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   clr    in  force the count back to 0 (wins over en)
//   en     in  advance the count by one this cycle
//   expire out high in the last enabled cycle of a TIMEOUT_CYCLES window
module ack_timer
  import link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: shares the wireless link transmitter between the host and
// player keypad paths, waits for a remote acknowledge and retries on timeout.
// Optional build macro LINK_TX_STATS_EN adds saturating retry/fail counters.
// Ports:
//   clk, nRst (sync, active-high reset), role_switch (first tie-break)
//   host_req/host_data/host_grant, player_req/player_data/player_grant
//   tx_valid/tx_data/tx_ready  : handshake to the transmitter
//   rx_ack                     : remote acknowledge pulse
//   msg_sent (pulse), error (sticky), busy
//   retry_count, fail_count    : only with LINK_TX_STATS_EN
//
// state    | meaning
// IDLE     | arbitrate between pending requests
// SEND     | offer latched byte until the transmitter takes it
// WAIT_ACK | count toward timeout, watch rx_ack
// DONE     | one-cycle msg_sent, clear error/retry
// FAIL     | retries exhausted, error set, clear retry
module link_tx_arbiter
  import link_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              role_switch,
  input  logic              host_req,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_grant,
  input  logic              player_req,
  input  logic [DATA_W-1:0] player_data,
  output logic              player_grant,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_ack,
  output logic              msg_sent,
  output logic              error,
  output logic              busy
`ifdef LINK_TX_STATS_EN
  ,
  output logic [7:0]        retry_count,
  output logic [7:0]        fail_count
`endif
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arb_state_t        state_q, state_d;
  req_id_t           last_winner_q, last_winner_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              error_q, error_d;

  logic grant_host, grant_player;
  logic timer_clr, timer_en, timer_expire;
  logic ack_expired, can_retry;

  ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ack_timer (
    .clk    (clk),
    .rst    (nRst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Expiry only counts when no ack arrives in the same cycle: ack wins.
  assign ack_expired = timer_expire && !rx_ack;
  assign can_retry   = (retry_q < RW'(MAX_RETRY));

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    data_d        = data_q;
    retry_d       = retry_q;
    error_d       = error_q;
    grant_host    = 1'b0;
    grant_player  = 1'b0;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_req && player_req) begin
          // Round-robin only on ties; a lone requester does not move the pointer.
          if (last_winner_q == REQ_PLAYER) grant_host = 1'b1;
          else                             grant_player = 1'b1;
          last_winner_d = (last_winner_q == REQ_PLAYER) ? REQ_HOST : REQ_PLAYER;
        end else if (host_req) begin
          grant_host = 1'b1;
        end else if (player_req) begin
          grant_player = 1'b1;
        end
        if (grant_host) begin
          data_d  = host_data;
          state_d = SEND;
        end else if (grant_player) begin
          data_d  = player_data;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          timer_clr = 1'b1;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_en = 1'b1;
        if (rx_ack) begin
          state_d = DONE;
        end else if (ack_expired) begin
          if (can_retry) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            error_d = 1'b1;
            state_d = FAIL;
          end
        end
      end
      DONE: begin
        error_d = 1'b0;
        retry_d = '0;
        state_d = IDLE;
      end
      FAIL: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q       <= IDLE;
      last_winner_q <= req_id_t'(~role_switch);
      data_q        <= '0;
      retry_q       <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      data_q        <= data_d;
      retry_q       <= retry_d;
      error_q       <= error_d;
    end
  end

  // Gated with reset so an abort cycle never leaks a grant, offer or pulse.
  assign host_grant   = grant_host && !nRst;
  assign player_grant = grant_player && !nRst;
  assign tx_valid     = (state_q == SEND) && !nRst;
  assign msg_sent     = (state_q == DONE) && !nRst;
  assign busy         = (state_q != IDLE) && !nRst;
  assign tx_data      = data_q;
  assign error        = error_q;

`ifdef LINK_TX_STATS_EN
  logic [7:0] retry_count_q, retry_count_d;
  logic [7:0] fail_count_q, fail_count_d;

  always_comb begin
    retry_count_d = retry_count_q;
    fail_count_d  = fail_count_q;
    if (state_q == WAIT_ACK && ack_expired) begin
      if (can_retry) begin
        if (retry_count_q != 8'hFF) retry_count_d = retry_count_q + 8'd1;
      end else begin
        if (fail_count_q != 8'hFF) fail_count_d = fail_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      retry_count_q <= '0;
      fail_count_q  <= '0;
    end else begin
      retry_count_q <= retry_count_d;
      fail_count_q  <= fail_count_d;
    end
  end

  assign retry_count = retry_count_q;
  assign fail_count  = fail_count_q;
`endif

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Testbench for link_tx_arbiter: scenario tasks with a byte scoreboard.
module tb_link_tx_arbiter;

  logic       clk = 1'b0;
  logic       nRst;
  logic       role_switch;
  logic       host_req;
  logic [7:0] host_data;
  logic       host_grant;
  logic       player_req;
  logic [7:0] player_data;
  logic       player_grant;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_ack;
  logic       msg_sent;
  logic       error;
  logic       busy;
`ifdef LINK_TX_STATS_EN
  logic [7:0] retry_count;
  logic [7:0] fail_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  link_tx_arbiter dut (
    .clk          (clk),
    .nRst         (nRst),
    .role_switch  (role_switch),
    .host_req     (host_req),
    .host_data    (host_data),
    .host_grant   (host_grant),
    .player_req   (player_req),
    .player_data  (player_data),
    .player_grant (player_grant),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_ack       (rx_ack),
    .msg_sent     (msg_sent),
    .error        (error),
    .busy         (busy)
`ifdef LINK_TX_STATS_EN
    ,
    .retry_count  (retry_count),
    .fail_count   (fail_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rs);
    nRst = 1'b1; role_switch = rs; host_req = 1'b0; player_req = 1'b0;
    rx_ack = 1'b0; tx_ready = 1'b1;
    tick();
    tick();
    nRst = 1'b0;
  endtask

  function automatic logic [7:0] sb_pop();
    if (sb_q.size() == 0) return 8'hxx;
    return sb_q.pop_front();
  endfunction

  // Stimulus only: runs a granted transfer with immediate accept and ack one
  // cycle after acceptance; returns what it observed for the caller to judge.
  task automatic complete_xfer(input logic drop_h, input logic drop_p,
                               output logic [7:0] seen, output logic v, output logic m);
    tick(); if (drop_h) host_req = 1'b0; if (drop_p) player_req = 1'b0; #1;
    v = tx_valid; seen = tx_data;
    tick(); rx_ack = 1'b1; #1;
    tick(); rx_ack = 1'b0; #1;
    m = msg_sent;
    tick(); #1;
  endtask

  task automatic test_reset();
    nRst = 1'b1; role_switch = 1'b0; host_req = 1'b1; player_req = 1'b1;
    host_data = 8'h11; player_data = 8'h22; tx_ready = 1'b1; rx_ack = 1'b1;
    tick(); tick(); #1;
    n_cmp++; if (host_grant !== 1'b0) begin n_bad++; $display("FAIL reset_host_grant: got %b want 0", host_grant); end
    n_cmp++; if (player_grant !== 1'b0) begin n_bad++; $display("FAIL reset_player_grant: got %b want 0", player_grant); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_cmp++; if (msg_sent !== 1'b0) begin n_bad++; $display("FAIL reset_msg_sent: got %b want 0", msg_sent); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_host();
    logic [7:0] exp;
    apply_reset(1'b0);
    host_req = 1'b1; host_data = 8'h41; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL basic_grant: got %b want 1", host_grant); end
    sb_q.push_back(8'h41);
    tick(); host_req = 1'b0; #1;
    exp = sb_pop();
    n_cmp++; if (tx_valid !== 1'b1) begin n_bad++; $display("FAIL basic_tx_valid: got %b want 1", tx_valid); end
    n_cmp++; if (tx_data !== exp) begin n_bad++; $display("FAIL basic_tx_data: got %h want %h", tx_data, exp); end
    tick(); rx_ack = 1'b1; #1;
    n_cmp++; if (msg_sent !== 1'b0) begin n_bad++; $display("FAIL basic_msg_early: got %b want 0", msg_sent); end
    tick(); rx_ack = 1'b0; #1;
    n_cmp++; if (msg_sent !== 1'b1) begin n_bad++; $display("FAIL basic_msg_sent: got %b want 1", msg_sent); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", error); end
    tick(); #1;
    n_cmp++; if (msg_sent !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: got msg=%b busy=%b want 0 0", msg_sent, busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] seen, exp;
    logic v, m;
    apply_reset(1'b1);
    host_req = 1'b1; host_data = 8'h41; player_req = 1'b1; player_data = 8'h50; #1;
    n_cmp++; if (player_grant !== 1'b1 || host_grant !== 1'b0) begin n_bad++; $display("FAIL rr_first: got p=%b h=%b want 1 0", player_grant, host_grant); end
    sb_q.push_back(8'h50);
    complete_xfer(1'b0, 1'b1, seen, v, m);
    exp = sb_pop();
    n_cmp++; if (v !== 1'b1 || seen !== exp) begin n_bad++; $display("FAIL rr_first_data: got v=%b %h want 1 %h", v, seen, exp); end
    n_cmp++; if (m !== 1'b1) begin n_bad++; $display("FAIL rr_first_msg: got %b want 1", m); end
    n_cmp++; if (host_grant !== 1'b1 || player_grant !== 1'b0) begin n_bad++; $display("FAIL rr_second: got h=%b p=%b want 1 0", host_grant, player_grant); end
    sb_q.push_back(8'h41);
    complete_xfer(1'b1, 1'b0, seen, v, m);
    exp = sb_pop();
    n_cmp++; if (v !== 1'b1 || seen !== exp) begin n_bad++; $display("FAIL rr_second_data: got v=%b %h want 1 %h", v, seen, exp); end
    host_req = 1'b1; host_data = 8'h42; player_req = 1'b1; player_data = 8'h51; #1;
    n_cmp++; if (host_grant !== 1'b1 || player_grant !== 1'b0) begin n_bad++; $display("FAIL rr_third: got h=%b p=%b want 1 0", host_grant, player_grant); end
    sb_q.push_back(8'h42);
    complete_xfer(1'b1, 1'b1, seen, v, m);
    exp = sb_pop();
    n_cmp++; if (v !== 1'b1 || seen !== exp || m !== 1'b1) begin n_bad++; $display("FAIL rr_third_xfer: got v=%b %h m=%b want 1 %h 1", v, seen, m, exp); end
  endtask

  task automatic test_fail_retry();
    logic [7:0] exp, seen;
    logic v, m, prev_v, done;
    int rises, wait_cnt, gap, gap_bad, msg_cnt, data_bad;
    apply_reset(1'b0);
    player_req = 1'b1; player_data = 8'h48; #1;
    n_cmp++; if (player_grant !== 1'b1) begin n_bad++; $display("FAIL fail_grant: got %b want 1", player_grant); end
    sb_q.push_back(8'h48);
    exp = sb_pop();
    rises = 0; wait_cnt = 0; gap = 0; gap_bad = 0; msg_cnt = 0; data_bad = 0;
    prev_v = 1'b0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(); player_req = 1'b0; #1;
      if (msg_sent) msg_cnt++;
      if (tx_valid) begin
        if (!prev_v) begin
          rises++;
          if (rises > 1 && gap != 50) gap_bad++;
          gap = 0;
        end
        if (tx_data !== exp) data_bad++;
      end else if (busy) begin
        wait_cnt++; gap++;
      end else begin
        done = 1'b1;
      end
      prev_v = tx_valid;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fail_timeout: transfer still busy after 400 cycles"); end
    n_cmp++; if (rises != 4) begin n_bad++; $display("FAIL fail_sends: got %0d want 4", rises); end
    n_cmp++; if (gap_bad != 0) begin n_bad++; $display("FAIL fail_spacing: got %0d bad gaps want 0", gap_bad); end
    n_cmp++; if (wait_cnt != 201) begin n_bad++; $display("FAIL fail_wait_cycles: got %0d want 201 (200 wait + fail)", wait_cnt); end
    n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL fail_data: got %0d bad bytes want 0", data_bad); end
    n_cmp++; if (msg_cnt != 0) begin n_bad++; $display("FAIL fail_msg: got %0d want 0", msg_cnt); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL fail_error: got %b want 1", error); end
    host_req = 1'b1; host_data = 8'h43; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL fail_recover_grant: got %b want 1", host_grant); end
    sb_q.push_back(8'h43);
    complete_xfer(1'b1, 1'b0, seen, v, m);
    exp = sb_pop();
    n_cmp++; if (v !== 1'b1 || seen !== exp || m !== 1'b1) begin n_bad++; $display("FAIL fail_recover_xfer: got v=%b %h m=%b want 1 %h 1", v, seen, m, exp); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL fail_error_clear: got %b want 0", error); end
  endtask

  task automatic test_ack_at_timeout();
    logic [7:0] exp;
    int extra;
    host_req = 1'b1; host_data = 8'h54; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL edge_grant: got %b want 1", host_grant); end
    sb_q.push_back(8'h54);
    tick(); host_req = 1'b0; #1;
    exp = sb_pop();
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== exp) begin n_bad++; $display("FAIL edge_send: got v=%b %h want 1 %h", tx_valid, tx_data, exp); end
    extra = 0;
    for (int i = 1; i <= 50; i++) begin
      tick(); if (i == 50) rx_ack = 1'b1; #1;
      if (tx_valid) extra++;
    end
    tick(); rx_ack = 1'b0; #1;
    if (tx_valid) extra++;
    n_cmp++; if (msg_sent !== 1'b1) begin n_bad++; $display("FAIL edge_msg: got %b want 1", msg_sent); end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL edge_resend: got %0d resend cycles want 0", extra); end
    tick(); #1;
    n_cmp++; if (busy !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL edge_idle: got busy=%b err=%b want 0 0", busy, error); end
  endtask

  task automatic test_tx_stall();
    logic [7:0] exp;
    int bad;
    tx_ready = 1'b0; host_req = 1'b1; host_data = 8'h5A; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got %b want 1", host_grant); end
    sb_q.push_back(8'h5A);
    exp = sb_pop();
    bad = 0;
    for (int i = 1; i <= 21; i++) begin
      tick(); host_req = 1'b0; if (i == 21) tx_ready = 1'b1; #1;
      if (tx_valid !== 1'b1 || tx_data !== exp) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    tick(); rx_ack = 1'b1; #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL stall_accept: got %b want 0", tx_valid); end
    tick(); rx_ack = 1'b0; #1;
    n_cmp++; if (msg_sent !== 1'b1) begin n_bad++; $display("FAIL stall_msg: got %b want 1", msg_sent); end
    tick(); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp, seen;
    logic v, m;
    host_req = 1'b1; host_data = 8'h77; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL abort_grant: got %b want 1", host_grant); end
    sb_q.push_back(8'h77);
    tick(); host_req = 1'b0; #1;
    exp = sb_pop();
    n_cmp++; if (tx_data !== exp) begin n_bad++; $display("FAIL abort_data: got %h want %h", tx_data, exp); end
    tick(); tick(); nRst = 1'b1; rx_ack = 1'b1; #1;
    n_cmp++; if (msg_sent !== 1'b0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL abort_rst_cycle: got msg=%b v=%b want 0 0", msg_sent, tx_valid); end
    tick(); nRst = 1'b0; rx_ack = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || tx_valid !== 1'b0 || msg_sent !== 1'b0) begin n_bad++; $display("FAIL abort_after: got busy=%b v=%b msg=%b want 0 0 0", busy, tx_valid, msg_sent); end
    host_req = 1'b1; host_data = 8'h33; #1;
    n_cmp++; if (host_grant !== 1'b1) begin n_bad++; $display("FAIL abort_regrant: got %b want 1", host_grant); end
    sb_q.push_back(8'h33);
    complete_xfer(1'b1, 1'b0, seen, v, m);
    exp = sb_pop();
    n_cmp++; if (v !== 1'b1 || seen !== exp || m !== 1'b1) begin n_bad++; $display("FAIL abort_fresh_xfer: got v=%b %h m=%b want 1 %h 1", v, seen, m, exp); end
  endtask

  initial begin
    nRst = 1'b1; role_switch = 1'b0; host_req = 1'b0; player_req = 1'b0;
    host_data = 8'h00; player_data = 8'h00; tx_ready = 1'b1; rx_ack = 1'b0;
    test_reset();
    test_basic_host();
    test_round_robin();
    test_fail_retry();
    test_ack_at_timeout();
    test_tx_stall();
    test_reset_mid();
    n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
